// File: rtl/msix_sched_pkg.sv
// Shared types for the MSI-X request scheduler.
//   MSIX_VEC_W    : width of an MSI-X vector number
//   sched_state_e : scheduler FSM states (IDLE, ISSUE, GAP)
//   slot_t        : one-deep per-requester slot {valid, vector}
package msix_sched_pkg;

    localparam int MSIX_VEC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic                  valid;
        logic [MSIX_VEC_W-1:0] vector;
    } slot_t;

endpackage

// File: rtl/msix_rr_arb.sv
// Round-robin arbiter for the MSI-X scheduler.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : NUM_REQ-wide request vector
//   advance    : grant was consumed; move the pointer past the granted index
//   grant      : one-hot grant (all zero when no request)
// The search starts at the pointer, which always holds the index just
// after the last consumed grant, wrapping from NUM_REQ-1 to 0.
module msix_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic             found;
    int               idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/msix_req_scheduler.sv
// MSI-X request scheduler: collects one-cycle interrupt requests from
// NUM_REQ requesters into one-deep slots and issues them round-robin to
// the Tx MSI-X bridge, honouring a programmable idle gap between issues.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_strb     : per-requester request pulse
//   req_vector   : per-requester vector, sampled with req_strb
//   req_mask     : holds a pending request without issuing it
//   req_pending  : slot holds an unissued request
//   req_ovf      : sticky per-requester lost-request flag
//   ovf_clr      : clears the matching req_ovf bit
//   gap_cycles   : minimum idle cycles between issues
//   msix_strb    : one-cycle issue pulse (registered)
//   msix_num     : vector issued with msix_strb (registered)
//   msix_ready   : bridge can accept
//   issue_cnt    : running count of issued interrupts
module msix_req_scheduler
    import msix_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GAP_W   = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_strb,
    input  logic [NUM_REQ-1:0][MSIX_VEC_W-1:0]  req_vector,
    input  logic [NUM_REQ-1:0]                  req_mask,
    output logic [NUM_REQ-1:0]                  req_pending,
    output logic [NUM_REQ-1:0]                  req_ovf,
    input  logic [NUM_REQ-1:0]                  ovf_clr,
    input  logic [GAP_W-1:0]                    gap_cycles,
    output logic                                msix_strb,
    output logic [MSIX_VEC_W-1:0]               msix_num,
    input  logic                                msix_ready,
    output logic [31:0]                         issue_cnt
);

    slot_t                 slots [NUM_REQ];
    sched_state_e          state;
    sched_state_e          state_nxt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    ovf_set;
    logic                  fire;
    logic                  load_gap;
    logic                  dec_gap;
    logic [MSIX_VEC_W-1:0] grant_vec;

    always_comb begin
        eligible    = '0;
        req_pending = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i]    = slots[i].valid & ~req_mask[i];
            req_pending[i] = slots[i].valid;
        end
    end

    msix_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (eligible),
        .advance (fire),
        .grant   (grant)
    );

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_vec = grant_vec | slots[i].vector;
            end
        end
    end

    // A differing vector on a pending slot is lost, unless the slot is
    // being granted this cycle, in which case the new vector replaces it.
    always_comb begin
        ovf_set = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ovf_set[i] = req_strb[i] & slots[i].valid &
                         (slots[i].vector != req_vector[i]) &
                         ~(fire & grant[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The issue decision is taken in IDLE so that msix_strb/msix_num can be
    // registered and appear during the single ISSUE cycle. Returning through
    // IDLE even with no gap limits issues to one per two cycles, which covers
    // the bridge's one-cycle ready latency.
    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        load_gap  = 1'b0;
        dec_gap   = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((|eligible) && msix_ready) begin
                    fire      = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (gap_cycles != '0) begin
                    load_gap  = 1'b1;
                    state_nxt = ST_GAP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                dec_gap = 1'b1;
                if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slots[i] <= '0;
            end
            req_ovf   <= '0;
            msix_strb <= 1'b0;
            msix_num  <= '0;
            issue_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            msix_strb <= fire;
            if (fire) begin
                msix_num  <= grant_vec;
                issue_cnt <= issue_cnt + 32'd1;
            end

            if (load_gap) begin
                gap_cnt <= gap_cycles;
            end else if (dec_gap) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire && grant[i]) begin
                    if (req_strb[i]) begin
                        slots[i].vector <= req_vector[i];
                    end else begin
                        slots[i].valid <= 1'b0;
                    end
                end else if (req_strb[i] && !slots[i].valid) begin
                    slots[i].valid  <= 1'b1;
                    slots[i].vector <= req_vector[i];
                end
            end

            // Set wins over a simultaneous clear.
            req_ovf <= ovf_set | (req_ovf & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_msix_req_scheduler.sv
module tb_msix_req_scheduler;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req_strb;
    logic [3:0][15:0] req_vector;
    logic [3:0]       req_mask;
    logic [3:0]       req_pending;
    logic [3:0]       req_ovf;
    logic [3:0]       ovf_clr;
    logic [7:0]       gap_cycles;
    logic             msix_strb;
    logic [15:0]      msix_num;
    logic             msix_ready;
    logic [31:0]      issue_cnt;

    msix_req_scheduler #(.NUM_REQ(4), .GAP_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_strb    (req_strb),
        .req_vector  (req_vector),
        .req_mask    (req_mask),
        .req_pending (req_pending),
        .req_ovf     (req_ovf),
        .ovf_clr     (ovf_clr),
        .gap_cycles  (gap_cycles),
        .msix_strb   (msix_strb),
        .msix_num    (msix_num),
        .msix_ready  (msix_ready),
        .issue_cnt   (issue_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records every issue seen on the falling edge.
    logic [15:0] seen_num [256];
    int          seen_cyc [256];
    int          n_seen = 0;

    always @(negedge clk) begin
        if (msix_strb === 1'b1 && n_seen < 256) begin
            seen_num[n_seen] <= msix_num;
            seen_cyc[n_seen] <= cyc;
            n_seen           <= n_seen + 1;
        end
    end

    int          checks   = 0;
    int          failures = 0;
    int          rd_idx   = 0;
    int          t_drive  = 0;
    int          exp_cnt  = 0;
    logic [15:0] exp_q [$];

    typedef struct {
        int          slot;
        logic [15:0] vec;
        logic [15:0] exp_num;
        int          exp_lat;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] bits);
        @(negedge clk);
        req_strb = bits;
        t_drive  = cyc;
        @(negedge clk);
        req_strb = '0;
    endtask

    task automatic push_exp(input logic [15:0] v);
        exp_q.push_back(v);
        exp_cnt++;
    endtask

    // Wait (bounded) for n issues, then compare each against the scoreboard.
    task automatic expect_issues(input int n, input int budget, input string name);
        int          waited;
        logic [15:0] e;
        waited = 0;
        while (n_seen < rd_idx + n && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            if (n_seen <= rd_idx) begin
                failures++;
                $display("FAIL %s timeout issue %0d expected=%0h", name, k, e);
            end else begin
                if (seen_num[rd_idx] !== e) begin
                    failures++;
                    $display("FAIL %s issue %0d actual=%0h expected=%0h", name, k, seen_num[rd_idx], e);
                end
                rd_idx++;
            end
        end
    endtask

    task automatic chk_gaps(input int base, input int n, input int spacing, input string name);
        for (int k = 1; k < n; k++) begin
            chk(name, 32'(seen_cyc[base + k] - seen_cyc[base + k - 1]), 32'(spacing));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t_u;

        tbl[0] = '{slot: 0, vec: 16'h0005, exp_num: 16'h0005, exp_lat: 2};
        tbl[1] = '{slot: 1, vec: 16'h0000, exp_num: 16'h0000, exp_lat: 2};
        tbl[2] = '{slot: 2, vec: 16'h8001, exp_num: 16'h8001, exp_lat: 2};
        tbl[3] = '{slot: 3, vec: 16'hFFFF, exp_num: 16'hFFFF, exp_lat: 2};

        rst_n      = 1'b0;
        req_strb   = '0;
        req_vector = '0;
        req_mask   = '0;
        ovf_clr    = '0;
        gap_cycles = '0;
        msix_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_strb", 32'(msix_strb), 32'(0));
        chk("rst_num", 32'(msix_num), 32'(0));
        chk("rst_cnt", issue_cnt, 32'(0));
        chk("rst_pending", 32'(req_pending), 32'(0));
        chk("rst_ovf", 32'(req_ovf), 32'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single requests: 2-cycle latency, count increments, slot clears.
        for (int i = 0; i < 4; i++) begin
            req_vector[tbl[i].slot] = tbl[i].vec;
            strobe(4'(1 << tbl[i].slot));
            chk("tbl_pending_set", 32'(req_pending), 32'(1 << tbl[i].slot));
            push_exp(tbl[i].exp_num);
            base = rd_idx;
            expect_issues(1, 10, "tbl_issue");
            chk("tbl_latency", 32'(seen_cyc[base] - t_drive), 32'(tbl[i].exp_lat));
            chk("tbl_cnt", issue_cnt, 32'(exp_cnt));
            chk("tbl_pending_clr", 32'(req_pending), 32'(0));
        end

        // Fairness from pointer 0.
        for (int s = 0; s < 4; s++) req_vector[s] = 16'h0010 + 16'(s);
        strobe(4'b1111);
        push_exp(16'h0010); push_exp(16'h0011); push_exp(16'h0012); push_exp(16'h0013);
        base = rd_idx;
        expect_issues(4, 20, "rr_p0");
        chk("rr_p0_latency", 32'(seen_cyc[base] - t_drive), 32'(2));
        chk_gaps(base, 4, 2, "rr_p0_spacing");

        // Move the pointer to 2 by issuing slot 1 alone.
        req_vector[1] = 16'h0007;
        strobe(4'b0010);
        push_exp(16'h0007);
        expect_issues(1, 10, "rr_setup");

        for (int s = 0; s < 4; s++) req_vector[s] = 16'h0010 + 16'(s);
        strobe(4'b1111);
        push_exp(16'h0012); push_exp(16'h0013); push_exp(16'h0010); push_exp(16'h0011);
        base = rd_idx;
        expect_issues(4, 20, "rr_p2");
        chk_gaps(base, 4, 2, "rr_p2_spacing");
        chk("rr_cnt", issue_cnt, 32'(exp_cnt));

        // Strobe in the grant cycle reloads the slot without overflow.
        req_vector[0] = 16'h0030;
        @(negedge clk);
        req_strb = 4'b0001;
        @(negedge clk);
        req_vector[0] = 16'h0031;
        @(negedge clk);
        req_strb = '0;
        push_exp(16'h0030); push_exp(16'h0031);
        base = rd_idx;
        expect_issues(2, 12, "grant_reload");
        chk_gaps(base, 2, 2, "grant_reload_spacing");
        chk("grant_reload_ovf", 32'(req_ovf), 32'(0));

        // Coalesce and overflow on a masked slot.
        req_mask = 4'b0010;
        req_vector[1] = 16'h0020;
        strobe(4'b0010);
        chk("mask_pending", 32'(req_pending), 32'(4'b0010));
        strobe(4'b0010);
        chk("coalesce_ovf", 32'(req_ovf), 32'(0));
        req_vector[1] = 16'h0021;
        strobe(4'b0010);
        chk("ovf_set", 32'(req_ovf), 32'(4'b0010));
        repeat (3) @(negedge clk);
        chk("masked_no_issue", 32'(n_seen - rd_idx), 32'(0));
        chk("masked_retained", 32'(req_pending), 32'(4'b0010));
        push_exp(16'h0020);
        base = rd_idx;
        req_mask = '0;
        t_u = cyc;
        expect_issues(1, 10, "unmask_issue");
        chk("unmask_latency", 32'(seen_cyc[base] - t_u), 32'(1));
        chk("ovf_sticky", 32'(req_ovf), 32'(4'b0010));
        @(negedge clk); ovf_clr = 4'b0010;
        @(negedge clk); ovf_clr = '0;
        chk("ovf_clr", 32'(req_ovf), 32'(0));

        // Overflow set and clear in the same cycle: set wins.
        req_mask = 4'b0010;
        req_vector[1] = 16'h0040;
        strobe(4'b0010);
        req_vector[1] = 16'h0041;
        @(negedge clk);
        req_strb = 4'b0010;
        ovf_clr  = 4'b0010;
        @(negedge clk);
        req_strb = '0;
        ovf_clr  = '0;
        chk("ovf_set_wins", 32'(req_ovf), 32'(4'b0010));
        @(negedge clk); ovf_clr = 4'b0010;
        @(negedge clk); ovf_clr = '0;
        push_exp(16'h0040);
        req_mask = '0;
        expect_issues(1, 10, "set_wins_issue");

        // Gap of 3: issues 5 cycles apart.
        gap_cycles = 8'd3;
        req_vector[0] = 16'h0050;
        req_vector[1] = 16'h0051;
        strobe(4'b0011);
        push_exp(16'h0050); push_exp(16'h0051);
        base = rd_idx;
        expect_issues(2, 20, "gap");
        chk_gaps(base, 2, 5, "gap_spacing");

        // Backpressure: nothing issued while not ready, both retained.
        msix_ready = 1'b0;
        req_vector[2] = 16'h0060;
        req_vector[3] = 16'h0061;
        strobe(4'b1100);
        repeat (10) @(negedge clk);
        chk("bp_no_issue", 32'(n_seen - rd_idx), 32'(0));
        chk("bp_retained", 32'(req_pending), 32'(4'b1100));
        msix_ready = 1'b1;
        push_exp(16'h0060); push_exp(16'h0061);
        base = rd_idx;
        expect_issues(2, 20, "bp_resume");
        chk_gaps(base, 2, 5, "bp_spacing");
        chk("bp_cnt", issue_cnt, 32'(exp_cnt));
        repeat (6) @(negedge clk);

        // Reset mid-GAP with slot 2 still pending.
        req_vector[0] = 16'h0070;
        req_vector[2] = 16'h0072;
        strobe(4'b0101);
        push_exp(16'h0070);
        expect_issues(1, 10, "pre_reset_issue");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midgap_rst_strb", 32'(msix_strb), 32'(0));
        chk("midgap_rst_num", 32'(msix_num), 32'(0));
        chk("midgap_rst_cnt", issue_cnt, 32'(0));
        chk("midgap_rst_pending", 32'(req_pending), 32'(0));
        chk("midgap_rst_ovf", 32'(req_ovf), 32'(0));
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_no_issue", 32'(n_seen - rd_idx), 32'(0));

        // Fresh request after reset counts from zero.
        gap_cycles = '0;
        req_vector[2] = 16'h0099;
        strobe(4'b0100);
        exp_q.push_back(16'h0099);
        expect_issues(1, 10, "post_rst_issue");
        chk("post_rst_cnt", issue_cnt, 32'(1));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msix_req_scheduler.md
MSIX_REQ_SCHEDULER -- requirements
Module: msix_req_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of MSI-X requesters (2..16).
REQ-002 Parameter GAP_W, default 8: width of the inter-issue gap counter.
REQ-003 Port clk, input, 1: single clock; all logic is synchronous to its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset, asserted asynchronously and released synchronously to clk.
REQ-005 Port req_strb, input, NUM_REQ: one-cycle request pulse per requester.
REQ-006 Port req_vector, input, NUM_REQ x 16: vector number per requester, sampled with req_strb.
REQ-007 Port req_mask, input, NUM_REQ: 1 holds that requester's pending request without issuing it.
REQ-008 Port req_pending, output, NUM_REQ: slot holds an unissued request.
REQ-009 Port req_ovf, output, NUM_REQ: sticky flag, set when a request is lost.
REQ-010 Port ovf_clr, input, NUM_REQ: clears the matching req_ovf bit.
REQ-011 Port gap_cycles, input, GAP_W: minimum idle cycles between consecutive issues (0 = back-to-back).
REQ-012 Port msix_strb, output, 1: one-cycle issue pulse to the Tx MSI-X bridge.
REQ-013 Port msix_num, output, 16: vector issued with msix_strb.
REQ-014 Port msix_ready, input, 1: bridge can accept; registered and almost-full based in the bridge.
REQ-015 Port issue_cnt, output, 32: count of issued interrupts, wraps modulo 2^32.

Function
REQ-016 Each requester SHALL own a one-deep slot {valid, vector[15:0]}; a req_strb on an empty slot loads the slot and sets valid the next cycle.
REQ-017 A req_strb on a pending slot with the same vector SHALL coalesce: no state change and no overflow.
REQ-018 A req_strb on a pending slot with a different vector SHALL keep the old vector and set req_ovf.
REQ-019 A req_strb in the same cycle as that slot's grant SHALL load the new vector, with valid remaining set; this is not an overflow.
REQ-020 Eligible = valid AND NOT req_mask; grant SHALL be round-robin among eligible slots, starting after the last granted index, and SHALL wrap from NUM_REQ-1 to 0.
REQ-021 Scheduler FSM states: IDLE, ISSUE, GAP.
REQ-022 IDLE->ISSUE when any slot is eligible and msix_ready=1; otherwise remain in IDLE.
REQ-023 ISSUE SHALL last one cycle: msix_strb=1, msix_num=granted vector, clear granted slot (subject to REQ-019), increment issue_cnt, update the round-robin pointer.
REQ-024 ISSUE->GAP when gap_cycles!=0, loading the gap counter with gap_cycles; ISSUE->IDLE otherwise.
REQ-025 GAP SHALL decrement the counter and go to IDLE when it reaches 1.
REQ-026 Latency: a req_strb on an empty, unmasked slot with the scheduler idle and msix_ready=1 SHALL produce msix_strb exactly 2 cycles later.
REQ-027 Back-to-back issue with gap_cycles=0 SHALL be at most one per 2 cycles, covering the bridge's one-cycle ready latency.
REQ-028 msix_ready deasserting SHALL never cancel an ISSUE already entered.
REQ-029 Masking a slot SHALL retain its pending request; unmasking SHALL make it eligible the next cycle.
REQ-030 If ovf_clr and an overflow set occur in the same cycle, set SHALL win.
REQ-031 msix_strb and msix_num SHALL be driven from registers (no combinational input-to-output path).

Reset
REQ-032 On rst_n low: all slots invalid, req_ovf=0, msix_strb=0, msix_num=0, issue_cnt=0, round-robin pointer=0, FSM=IDLE, gap counter=0.
REQ-033 Reset asserted mid-GAP or mid-ISSUE SHALL abort the operation, discard pending requests, and issue no strobe after release until a new req_strb is received.

Structure
REQ-034 Shared package msix_sched_pkg SHALL hold the FSM state enum, the slot struct {valid, vector}, and the constant MSIX_VEC_W=16.
REQ-035 Round-robin grant logic SHALL live in sub-module msix_rr_arb (NUM_REQ-wide request, one-hot grant, pointer update on an advance strobe).

Verification
REQ-036 Single request: req_strb[0], vector 0x0005 -> msix_strb with msix_num=0x0005 two cycles later; issue_cnt=1.
REQ-037 Fairness: all 4 slots strobed together, vectors 0x10..0x13, gap 0 -> issues 0x10, 0x11, 0x12, 0x13 every second cycle; rerun with pointer at 2 -> order 0x12, 0x13, 0x10, 0x11.
REQ-038 Overflow and coalesce: slot 1 pending 0x20, masked; strobe 0x20 -> no ovf; strobe 0x21 -> req_ovf[1]=1; unmask -> 0x20 issued; ovf_clr[1] -> req_ovf[1]=0.
REQ-039 Gap and backpressure: gap_cycles=3, two slots pending -> issues 5 cycles apart; msix_ready=0 for 10 cycles -> no strobe, both slots retained, issued after ready returns.
REQ-040 Reset mid-GAP: rst_n pulsed low while slot 2 is pending -> all outputs at reset values, no msix_strb after release.
